// File: rtl/evt_mask_prescaler.sv
// -----------------------------------------------------------------------------
// evt_mask_prescaler
//
// Multi-channel event prescaler / mask generator for the PWM carrier block.
// Each channel detects rising edges of its carrier event (zero/period match),
// counts them and emits a one-cycle mask pulse every (compare+1) events. The
// mask pulse is used downstream to gate interrupt and update generation.
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   reset        asynchronous, active-high reset of all state
//   sync_clr     synchronous clear of every channel (highest priority)
//   int_on       global interrupt enable, gates every mask pulse
//   event_in     per-channel carrier event level (synchronous to clk)
//   pwm_on       per-channel PWM enable
//   count_en     per-channel count enable
//   mask_mode    per-channel mode, bits [2c+1:2c]:
//                  00 NO_MASK, 01 PERIODIC, 10 ONE_SHOT, 11 PERIODIC
//   event_count  per-channel compare value, bits [WIDTH*c +: WIDTH]
//   mask_out     per-channel one-cycle mask pulse (registered)
//   event_timer  per-channel current event count (status)
//   done         per-channel sticky "one-shot has fired" flag
// -----------------------------------------------------------------------------
module evt_mask_prescaler #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sync_clr,
  input  logic                      int_on,
  input  logic [CHANNELS-1:0]       event_in,
  input  logic [CHANNELS-1:0]       pwm_on,
  input  logic [CHANNELS-1:0]       count_en,
  input  logic [2*CHANNELS-1:0]     mask_mode,
  input  logic [WIDTH*CHANNELS-1:0] event_count,
  output logic [CHANNELS-1:0]       mask_out,
  output logic [WIDTH*CHANNELS-1:0] event_timer,
  output logic [CHANNELS-1:0]       done
);

  localparam logic [1:0]       MODE_NO_MASK  = 2'b00;
  localparam logic [1:0]       MODE_ONE_SHOT = 2'b10;
  localparam logic [WIDTH-1:0] TIMER_ZERO    = '0;
  localparam logic [WIDTH-1:0] TIMER_ONE     = WIDTH'(1);

  // Previous event level for edge detection. Resets to all ones so that an
  // event level that is already high when reset releases is not counted.
  // It keeps tracking event_in even during sync_clr, so a level that is high
  // across a clear is not seen as a fresh edge afterwards.
  logic [CHANNELS-1:0] event_q_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_q_reg <= '1;
    end else begin
      event_q_reg <= event_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] timer_reg;
      logic [WIDTH-1:0] compare_reg;
      logic             mask_reg;
      logic             done_reg;

      logic [1:0]       mode;
      logic [WIDTH-1:0] compare_in;
      logic             rise;
      logic             act;
      logic             no_mask;
      logic             one_shot;
      logic             step;
      logic             match;

      assign mode       = mask_mode[2*gi +: 2];
      assign compare_in = event_count[WIDTH*gi +: WIDTH];
      assign rise       = event_in[gi] & ~event_q_reg[gi];
      assign act        = pwm_on[gi] & count_en[gi];
      assign no_mask    = (mode == MODE_NO_MASK);
      assign one_shot   = (mode == MODE_ONE_SHOT);

      // A fired one-shot freezes the counter until the next clear.
      assign step  = rise & act & ~(one_shot & done_reg);

      // >= rather than == so that a timer that somehow lies beyond the
      // compare value still terminates the period instead of running on.
      assign match = step & (timer_reg >= compare_reg);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          timer_reg   <= TIMER_ZERO;
          compare_reg <= TIMER_ZERO;
          mask_reg    <= 1'b0;
          done_reg    <= 1'b0;
        end else if (sync_clr) begin
          // Clear wins over any coincident edge; the edge is simply lost.
          timer_reg   <= TIMER_ZERO;
          compare_reg <= compare_in;
          mask_reg    <= 1'b0;
          done_reg    <= 1'b0;
        end else begin
          // Counter: held at zero while the channel is inactive.
          if (!act) begin
            timer_reg <= TIMER_ZERO;
          end else if (step) begin
            timer_reg <= match ? TIMER_ZERO : timer_reg + TIMER_ONE;
          end

          // Shadow compare: only refreshed while idle at a period boundary,
          // so a compare write never truncates or stretches a running period.
          if ((timer_reg == TIMER_ZERO) && !step) begin
            compare_reg <= compare_in;
          end

          // Mask pulse. NO_MASK passes every edge even on an inactive
          // channel; the other modes only pulse at the end of a period.
          if (no_mask) begin
            mask_reg <= rise & int_on;
          end else if (one_shot) begin
            mask_reg <= match & int_on & ~done_reg;
          end else begin
            mask_reg <= match & int_on;
          end

          if (one_shot && match) begin
            done_reg <= 1'b1;
          end
        end
      end

      assign event_timer[WIDTH*gi +: WIDTH] = timer_reg;
      assign mask_out[gi]                   = mask_reg;
      assign done[gi]                       = done_reg;
    end
  endgenerate

endmodule

// File: tb/tb_evt_mask_prescaler.sv
// -----------------------------------------------------------------------------
// tb_evt_mask_prescaler
//
// Directed bench for evt_mask_prescaler. A per-channel behavioural model
// ("events seen in the current period" against a shadowed period length)
// is compared to the DUT one time unit after every rising clock edge, and the
// directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_evt_mask_prescaler;
  localparam int CH = 8;
  localparam int W  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            sync_clr;
  logic            int_on;
  logic [CH-1:0]   event_in;
  logic [CH-1:0]   pwm_on;
  logic [CH-1:0]   count_en;
  logic [2*CH-1:0] mask_mode;
  logic [W*CH-1:0] event_count;
  logic [CH-1:0]   mask_out;
  logic [W*CH-1:0] event_timer;
  logic [CH-1:0]   done;

  int vectors     = 0;
  int miscompares = 0;

  evt_mask_prescaler #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .sync_clr    (sync_clr),
    .int_on      (int_on),
    .event_in    (event_in),
    .pwm_on      (pwm_on),
    .count_en    (count_en),
    .mask_mode   (mask_mode),
    .event_count (event_count),
    .mask_out    (mask_out),
    .event_timer (event_timer),
    .done        (done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model: per channel, how many events have been seen in the
  // current period, and the period length (compare+1) latched at a boundary.
  // ---------------------------------------------------------------------------
  int m_seen [CH];
  int m_comp [CH];
  bit m_done [CH];
  bit m_prev [CH];
  bit m_mask [CH];

  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      bit ev, rise, act, oneshot, counted, hit, idle_boundary;
      int mode, cv;
      ev   = event_in[c];
      cv   = int'(event_count[W*c +: W]);
      mode = int'(mask_mode[2*c +: 2]);
      if (reset) begin
        m_seen[c] = 0; m_comp[c] = 0; m_done[c] = 0; m_mask[c] = 0; m_prev[c] = 1;
      end else begin
        rise = ev && !m_prev[c];
        act  = pwm_on[c] && count_en[c];
        if (sync_clr) begin
          m_seen[c] = 0; m_done[c] = 0; m_comp[c] = cv; m_mask[c] = 0;
        end else begin
          oneshot       = (mode == 2);
          counted       = rise && act && !(oneshot && m_done[c]);
          idle_boundary = (m_seen[c] == 0) && !counted;
          hit           = 0;
          if (!act) begin
            m_seen[c] = 0;
          end else if (counted) begin
            // Period holds compare+1 events; the last one closes it.
            if (m_seen[c] + 1 == m_comp[c] + 1) begin
              hit = 1; m_seen[c] = 0;
            end else begin
              m_seen[c] = m_seen[c] + 1;
            end
          end
          if (idle_boundary) m_comp[c] = cv;
          case (mode)
            0:       m_mask[c] = rise && int_on;
            2:       m_mask[c] = hit && int_on && !m_done[c];
            default: m_mask[c] = hit && int_on;
          endcase
          if (oneshot && hit) m_done[c] = 1;
        end
        m_prev[c] = ev;
      end
    end
    #1;
    vectors++;
    begin
      bit bad;
      bad = 0;
      for (int c = 0; c < CH; c++) begin
        if (mask_out[c] !== m_mask[c] || done[c] !== m_done[c] ||
            int'(event_timer[W*c +: W]) != m_seen[c] || $isunknown(event_timer[W*c +: W])) begin
          bad = 1;
          $display("FAIL model ch%0d t=%0t: got mask=%b done=%b timer=%0d, expected mask=%b done=%b timer=%0d",
                   c, $time, mask_out[c], done[c], event_timer[W*c +: W], m_mask[c], m_done[c], m_seen[c]);
        end
      end
      if (bad) miscompares++;
    end
  end

  // Count DUT mask pulses per channel, sampled mid-cycle.
  int pulses [CH];
  initial for (int c = 0; c < CH; c++) pulses[c] = 0;
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < CH; c++) if (mask_out[c] === 1'b1) pulses[c]++;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic int tmr(input int c);
    return int'(event_timer[W*c +: W]);
  endfunction

  // One event: high for one sampled edge, low for the next. Returns at the
  // falling edge after the counting edge, when mask_out shows that event.
  task automatic ev_pulse(input logic [CH-1:0] chs);
    @(negedge clk); event_in = chs;
    @(negedge clk); event_in = '0;
  endtask

  task automatic clr();
    @(negedge clk); sync_clr = 1'b1;
    @(negedge clk); sync_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int seq1 [4];
    int p;
    seq1 = '{1, 2, 0, 1};

    reset       = 1'b1;
    sync_clr    = 1'b0;
    int_on      = 1'b1;
    event_in    = 8'h01;
    pwm_on      = '1;
    count_en    = '1;
    mask_mode   = {CH{2'b01}};
    event_count = '0;
    event_count[3:0] = 4'd2;

    // Reset release with event_in[0] already high: nothing counted.
    repeat (2) @(negedge clk);
    check("rst_timer", tmr(0), 0);
    check("rst_mask", int'(mask_out), 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("hold_high_mask", int'(mask_out[0]), 0);
    end
    check("hold_high_timer", tmr(0), 0);
    event_in = '0;
    @(negedge clk);

    // compare=2 periodic: timer 1,2,0,1, pulse on third event only.
    for (int i = 0; i < 4; i++) begin
      ev_pulse(8'h01);
      check("p2_mask", int'(mask_out[0]), (i == 2) ? 1 : 0);
      check("p2_timer", tmr(0), seq1[i]);
    end

    // compare=0: every event pulses.
    event_count[3:0] = 4'd0;
    clr();
    for (int i = 0; i < 5; i++) begin
      ev_pulse(8'h01);
      check("p0_mask", int'(mask_out[0]), 1);
    end

    // compare=15: one pulse per 16 events.
    event_count[3:0] = 4'd15;
    clr();
    p = pulses[0];
    repeat (48) ev_pulse(8'h01);
    check("p15_pulses", pulses[0] - p, 3);
    check("p15_timer", tmr(0), 0);

    // Shadow compare: write lands only at the period boundary.
    event_count[3:0] = 4'd3;
    clr();
    ev_pulse(8'h01);
    check("shadow_t1", tmr(0), 1);
    event_count[3:0] = 4'd1;
    for (int i = 2; i <= 8; i++) begin
      ev_pulse(8'h01);
      check("shadow_mask", int'(mask_out[0]), (i == 4 || i == 6 || i == 8) ? 1 : 0);
    end

    // One-shot, compare=1.
    mask_mode[1:0]   = 2'b10;
    event_count[3:0] = 4'd1;
    clr();
    for (int i = 1; i <= 6; i++) begin
      ev_pulse(8'h01);
      check("os_mask", int'(mask_out[0]), (i == 2) ? 1 : 0);
    end
    check("os_done", int'(done[0]), 1);
    check("os_timer", tmr(0), 0);
    clr();
    check("os_clr_done", int'(done[0]), 0);
    check("os_clr_timer", tmr(0), 0);
    for (int i = 1; i <= 2; i++) begin
      ev_pulse(8'h01);
      check("os2_mask", int'(mask_out[0]), (i == 2) ? 1 : 0);
    end
    check("os2_done", int'(done[0]), 1);

    // Mixed channels, simultaneous events on all eight.
    mask_mode        = {CH{2'b01}};
    mask_mode[1:0]   = 2'b00;
    event_count      = '0;
    event_count[7:4] = 4'd1;
    event_count[11:8] = 4'd1;
    pwm_on           = 8'hFB;
    clr();
    for (int i = 1; i <= 4; i++) begin
      ev_pulse(8'hFF);
      check("mix_ch0", int'(mask_out[0]), 1);
      check("mix_ch1", int'(mask_out[1]), (i % 2 == 0) ? 1 : 0);
      check("mix_ch2", int'(mask_out[2]), 0);
      check("mix_ch2_timer", tmr(2), 0);
      check("mix_ch7", int'(mask_out[7]), 1);
    end
    int_on = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ev_pulse(8'hFF);
      check("noint_mask", int'(mask_out), 0);
      check("noint_ch1_timer", tmr(1), i % 2);
    end
    int_on = 1'b1;
    pwm_on = '1;

    // Async reset mid-period.
    mask_mode         = {CH{2'b01}};
    mask_mode[7:6]    = 2'b10;
    event_count       = '0;
    event_count[3:0]  = 4'd5;
    clr();
    ev_pulse(8'h0B);
    ev_pulse(8'h0B);
    check("pre_rst_timer", tmr(0), 2);
    check("pre_rst_done3", int'(done[3]), 1);
    check("pre_rst_mask1", int'(mask_out[1]), 1);
    #2 reset = 1'b1;
    #1;
    check("async_timer", int'(event_timer), 0);
    check("async_done", int'(done), 0);
    check("async_mask", int'(mask_out), 0);
    @(negedge clk);
    event_count[3:0] = 4'd0;
    reset = 1'b0;
    @(negedge clk);

    // sync_clr coincident with a rise: the rise is lost.
    @(negedge clk);
    event_in = 8'h01; sync_clr = 1'b1;
    @(negedge clk);
    check("clr_rise_timer", tmr(0), 0);
    check("clr_rise_mask", int'(mask_out[0]), 0);
    event_in = '0; sync_clr = 1'b0;
    ev_pulse(8'h01);
    check("after_clr_mask", int'(mask_out[0]), 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
